// File: rtl/systolic_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_ctrl_pkg
//  Brief    : Shared types and helpers for the systolic array sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package systolic_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        FEED    = 3'd2,
        CAPTURE = 3'd3,
        HOLD    = 3'd4
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    function automatic int acc_w(input int data_width);
        return 2 * data_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_mat_buf.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_mat_buf
//  Brief    : SIZE x SIZE operand register file; reads column k (COL_READ=1)
//             or row k (COL_READ=0) as a packed vector, element 0 in LSBs.
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_mat_buf #(
    parameter int SIZE       = 3,
    parameter int DATA_WIDTH = 8,
    parameter bit COL_READ   = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_wr_en,
    input  logic [$clog2(SIZE)-1:0]       i_wr_row,
    input  logic [$clog2(SIZE)-1:0]       i_wr_col,
    input  logic [DATA_WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(SIZE)-1:0]       i_rd_idx,
    output logic [SIZE*DATA_WIDTH-1:0]    o_rd_vec
);

    logic [DATA_WIDTH-1:0] r_mem [SIZE][SIZE];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SIZE; i++)
                for (int j = 0; j < SIZE; j++)
                    r_mem[i][j] <= '0;
        end else if (i_wr_en && (int'(i_wr_row) < SIZE) && (int'(i_wr_col) < SIZE)) begin
            r_mem[i_wr_row][i_wr_col] <= i_wr_data;
        end
    end

    generate
        if (COL_READ) begin : g_col
            always_comb begin
                o_rd_vec = '0;
                for (int i = 0; i < SIZE; i++)
                    o_rd_vec[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[i][i_rd_idx];
            end
        end else begin : g_row
            always_comb begin
                o_rd_vec = '0;
                for (int j = 0; j < SIZE; j++)
                    o_rd_vec[j*DATA_WIDTH +: DATA_WIDTH] = r_mem[i_rd_idx][j];
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_seq_ctrl
//  Brief    : Sequencer for a broadcast SIZE x SIZE systolic array computing
//             C = A x B. Optional macro SYS_CTRL_PERF_EN adds perf counters.
//             Packing: arr_a/arr_b element i at [i*DW +: DW]; arr_c/res_c
//             element (i,j) at [(i*SIZE+j)*2DW +: 2DW].
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_seq_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int SIZE       = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       ld_en,
    input  logic                                       ld_sel,
    input  logic [$clog2(SIZE)-1:0]                    ld_row,
    input  logic [$clog2(SIZE)-1:0]                    ld_col,
    input  logic signed [DATA_WIDTH-1:0]               ld_data,
    input  logic                                       start,
    output logic                                       start_ready,
    output logic                                       busy,
    output logic                                       arr_clear,
    output logic [SIZE*DATA_WIDTH-1:0]                 arr_a,
    output logic [SIZE*DATA_WIDTH-1:0]                 arr_b,
    input  logic [SIZE*SIZE*acc_w(DATA_WIDTH)-1:0]     arr_c,
    output logic                                       res_valid,
    input  logic                                       res_ready,
`ifdef SYS_CTRL_PERF_EN
    output logic [31:0]                                perf_cycles,
    output logic [15:0]                                perf_jobs,
`endif
    output logic [SIZE*SIZE*acc_w(DATA_WIDTH)-1:0]     res_c
);

    localparam int                IDX_W      = $clog2(SIZE);
    localparam logic [IDX_W-1:0]  c_k_last   = IDX_W'(SIZE - 1);

    state_t                       r_state;
    logic [IDX_W-1:0]             r_k;
    logic                         w_idle;
    logic                         w_wr_a;
    logic                         w_wr_b;
    logic [IDX_W-1:0]             w_rd_idx;
    logic [SIZE*DATA_WIDTH-1:0]   w_col_a;
    logic [SIZE*DATA_WIDTH-1:0]   w_row_b;

    assign w_idle = (r_state == IDLE);
    assign w_wr_a = ld_en && w_idle && (ld_sel == SEL_A);
    assign w_wr_b = ld_en && w_idle && (ld_sel == SEL_B);
    // Operands are registered one step ahead: CLEAR fetches k=0, FEED fetches k+1.
    assign w_rd_idx = (r_state == CLEAR) ? '0 : (r_k + IDX_W'(1));

    systolic_mat_buf #(
        .SIZE       (SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .COL_READ   (1'b1)
    ) u_buf_a (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_a),
        .i_wr_row  (ld_row),
        .i_wr_col  (ld_col),
        .i_wr_data (ld_data),
        .i_rd_idx  (w_rd_idx),
        .o_rd_vec  (w_col_a)
    );

    systolic_mat_buf #(
        .SIZE       (SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .COL_READ   (1'b0)
    ) u_buf_b (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_b),
        .i_wr_row  (ld_row),
        .i_wr_col  (ld_col),
        .i_wr_data (ld_data),
        .i_rd_idx  (w_rd_idx),
        .o_rd_vec  (w_row_b)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_k         <= '0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            arr_clear   <= 1'b0;
            arr_a       <= '0;
            arr_b       <= '0;
            res_valid   <= 1'b0;
            res_c       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= CLEAR;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        arr_clear   <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_state   <= FEED;
                    r_k       <= '0;
                    arr_clear <= 1'b0;
                    arr_a     <= w_col_a;
                    arr_b     <= w_row_b;
                end
                FEED: begin
                    if (r_k == c_k_last) begin
                        r_state <= CAPTURE;
                        r_k     <= '0;
                        arr_a   <= '0;
                        arr_b   <= '0;
                    end else begin
                        r_k   <= r_k + IDX_W'(1);
                        arr_a <= w_col_a;
                        arr_b <= w_row_b;
                    end
                end
                CAPTURE: begin
                    r_state   <= HOLD;
                    res_c     <= arr_c;
                    res_valid <= 1'b1;
                end
                HOLD: begin
                    if (res_ready) begin
                        r_state     <= IDLE;
                        res_valid   <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef SYS_CTRL_PERF_EN
    logic [31:0] r_cyc;

    // r_cyc starts at 1 so the start-acceptance cycle itself is counted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cyc       <= '0;
            perf_cycles <= '0;
            perf_jobs   <= '0;
        end else begin
            if (w_idle && start)
                r_cyc <= 32'd1;
            else if (busy)
                r_cyc <= r_cyc + 32'd1;
            if ((r_state == HOLD) && res_ready) begin
                perf_cycles <= r_cyc + 32'd1;
                perf_jobs   <= perf_jobs + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_seq_ctrl
//  Brief    : Self-checking bench for systolic_seq_ctrl with a behavioural
//             array and a scoreboard of reference products.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_seq_ctrl;
    import systolic_ctrl_pkg::*;

    localparam int SIZE  = 3;
    localparam int DW    = 8;
    localparam int AW    = 2 * DW;
    localparam int VEC_W = SIZE * DW;
    localparam int MAT_W = SIZE * SIZE * AW;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld_en, ld_sel, start, res_ready;
    logic [1:0]        ld_row, ld_col;
    logic [DW-1:0]     ld_data;
    logic              start_ready, busy, arr_clear, res_valid;
    logic [VEC_W-1:0]  arr_a, arr_b;
    logic [MAT_W-1:0]  arr_c, res_c;
`ifdef SYS_CTRL_PERF_EN
    logic [31:0]       perf_cycles;
    logic [15:0]       perf_jobs;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_jobs   = 0;
    int ma [SIZE][SIZE];
    int mb [SIZE][SIZE];
    logic [MAT_W-1:0] sb_q [$];
    logic signed [AW-1:0] acc [SIZE][SIZE];

    always #5 clk = ~clk;

    systolic_seq_ctrl #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_en       (ld_en),
        .ld_sel      (ld_sel),
        .ld_row      (ld_row),
        .ld_col      (ld_col),
        .ld_data     (ld_data),
        .start       (start),
        .start_ready (start_ready),
        .busy        (busy),
        .arr_clear   (arr_clear),
        .arr_a       (arr_a),
        .arr_b       (arr_b),
        .arr_c       (arr_c),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
`ifdef SYS_CTRL_PERF_EN
        .perf_cycles (perf_cycles),
        .perf_jobs   (perf_jobs),
`endif
        .res_c       (res_c)
    );

    function automatic logic signed [AW-1:0] mulw(input logic signed [DW-1:0] x, input logic signed [DW-1:0] y);
        logic signed [AW-1:0] xx, yy;
        xx = x;
        yy = y;
        return xx * yy;
    endfunction

    // Broadcast array: PE(i,j) accumulates a[i]*b[j] every cycle, cleared synchronously.
    always @(posedge clk) begin
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                if (arr_clear) acc[i][j] <= '0;
                else acc[i][j] <= acc[i][j] + mulw(arr_a[i*DW +: DW], arr_b[j*DW +: DW]);
    end

    always_comb begin
        arr_c = '0;
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                arr_c[(i*SIZE+j)*AW +: AW] = acc[i][j];
    end

    function automatic logic [MAT_W-1:0] model_mult();
        logic [MAT_W-1:0] m;
        int s;
        m = '0;
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                s = 0;
                for (int k = 0; k < SIZE; k++) s += ma[i][k] * mb[k][j];
                m[(i*SIZE+j)*AW +: AW] = AW'(s);
            end
        return m;
    endfunction

    function automatic logic [VEC_W-1:0] col_a(input int k);
        logic [VEC_W-1:0] v;
        for (int i = 0; i < SIZE; i++) v[i*DW +: DW] = DW'(ma[i][k]);
        return v;
    endfunction

    function automatic logic [VEC_W-1:0] row_b(input int k);
        logic [VEC_W-1:0] v;
        for (int j = 0; j < SIZE; j++) v[j*DW +: DW] = DW'(mb[k][j]);
        return v;
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic model_write(input bit sel, input int r, input int c, input int d);
        logic signed [DW-1:0] v;
        v = DW'(d);
        if (r < SIZE && c < SIZE) begin
            if (sel) mb[r][c] = int'(v);
            else     ma[r][c] = int'(v);
        end
    endtask

    task automatic ld(input bit sel, input int r, input int c, input int d);
        ld_en = 1'b1; ld_sel = sel; ld_row = 2'(r); ld_col = 2'(c); ld_data = DW'(d);
        if (start_ready) model_write(sel, r, c, d);
        step();
        ld_en = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                ma[i][j] = 0;
                mb[i][j] = 0;
            end
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b0; start = 1'b0; ld_en = 1'b0; res_ready = 1'b0;
        repeat (ncyc) step();
        rst = 1'b1;
        model_clear();
        n_jobs = 0;
        #1;
        check("rst_start_ready", start_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_arr_clear", arr_clear, 0);
        check("rst_arr_ab", {arr_a, arr_b}, 0);
        check("rst_res_c", res_c, 0);
`ifdef SYS_CTRL_PERF_EN
        check("rst_perf", {perf_cycles, perf_jobs}, 0);
`endif
    endtask

    task automatic run_job(input int stall, input bit co_ld, input int cr, input int cc, input int cd, input bit ign);
        logic [MAT_W-1:0] exp_m;
        int cyc, nclr, clr_cyc;
        bit got;
        if (co_ld) begin
            ld_en = 1'b1; ld_sel = SEL_A; ld_row = 2'(cr); ld_col = 2'(cc); ld_data = DW'(cd);
            model_write(1'b0, cr, cc, cd);
        end
        exp_m = model_mult();
        sb_q.push_back(exp_m);
        res_ready = (stall == 0);
        check("idle_start_ready", start_ready, 1);
        start = 1'b1;
        step();
        start = 1'b0; ld_en = 1'b0;
        cyc = 1; nclr = 0; clr_cyc = 0; got = 0;
        for (int n = 0; n < 4*SIZE+10; n++) begin
            #1;
            if (arr_clear) begin nclr++; clr_cyc = cyc; end
            if (cyc == 1) check("busy_clear", busy, 1);
            if (cyc == 2) begin
                check("feed_a_k0", arr_a, col_a(0));
                check("feed_b_k0", arr_b, row_b(0));
            end
            if (cyc == SIZE+2) check("capture_ops_zero", {arr_a, arr_b}, 0);
            if (res_valid) begin got = 1; break; end
            step();
            cyc++;
        end
        check("valid_seen", got, 1);
        check("latency", cyc, SIZE+3);
        check("clear_pulses", nclr, 1);
        check("clear_cycle", clr_cyc, 1);
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", res_valid, 1);
            check("stall_res_c", res_c, exp_m);
            if (ign) begin
                start = (s == 1);
                if (s == 2) begin
                    ld_en = 1'b1; ld_sel = SEL_A; ld_row = 2'd0; ld_col = 2'd0; ld_data = 8'd7;
                end
            end
            step();
            start = 1'b0; ld_en = 1'b0;
            #1;
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        #1;
        check("post_start_ready", start_ready, 1);
        check("post_busy", busy, 0);
        check("post_res_valid", res_valid, 0);
`ifdef SYS_CTRL_PERF_EN
        check("perf_cycles", perf_cycles, SIZE + 4 + stall);
        check("perf_jobs", perf_jobs, 16'(n_jobs));
`endif
        #1;
    endtask

    // Scoreboard monitor: pops one expected product per result handshake.
    initial begin
        logic [MAT_W-1:0] exp_m;
        forever begin
            @(negedge clk);
            if (rst && res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    exp_m = sb_q.pop_front();
                    check("res_c", res_c, exp_m);
                    n_jobs++;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ld_en = 1'b0; ld_sel = 1'b0; ld_row = '0; ld_col = '0; ld_data = '0;
        start = 1'b0; res_ready = 1'b0; rst = 1'b0;
        do_reset(2);

        // A = 1..9, B = identity
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                ld(SEL_A, i, j, i*SIZE + j + 1);
                ld(SEL_B, i, j, (i == j) ? 1 : 0);
            end
        run_job(0, 1'b0, 0, 0, 0, 1'b0);

        // A all 2 (last element written together with start), B all 3
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                ld(SEL_A, i, j, (i == SIZE-1 && j == SIZE-1) ? 0 : 2);
                ld(SEL_B, i, j, 3);
            end
        run_job(0, 1'b1, SIZE-1, SIZE-1, 2, 1'b0);

        // Most negative operands wrap; stalled result with ignored start/writes
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                ld(SEL_A, i, j, -128);
                ld(SEL_B, i, j, -128);
            end
        run_job(5, 1'b0, 0, 0, 0, 1'b1);
        run_job(0, 1'b0, 0, 0, 0, 1'b0);

        // Abort during the second FEED cycle
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        do_reset(1);
        run_job(0, 1'b0, 0, 0, 0, 1'b0);

        // Back-to-back jobs with B = 2 x identity
        do_reset(1);
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                ld(SEL_A, i, j, int'($urandom_range(0, 255)));
                ld(SEL_B, i, j, (i == j) ? 2 : 0);
            end
        run_job(0, 1'b0, 0, 0, 0, 1'b0);
        run_job(0, 1'b0, 0, 0, 0, 1'b0);

        // Randomised jobs including out-of-range writes
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < SIZE; i++)
                for (int j = 0; j < SIZE; j++) begin
                    ld(SEL_A, i, j, int'($urandom_range(0, 255)));
                    ld(SEL_B, i, j, int'($urandom_range(0, 255)));
                end
            ld(1'($urandom_range(0, 1)), 3, int'($urandom_range(0, 3)), 8'h55);
            ld(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 3, 8'h2A);
            run_job(int'($urandom_range(0, 4)), 1'b0, 0, 0, 0, 1'b1);
        end

        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
